// File: rtl/dac_pkg.sv
// Shared constants and FSM encoding for the DAC burst sequencer and its sample table.
package dac_pkg;
   localparam int DAC_DATA_W = 16;
   localparam int DAC_ADDR_W = 6;
   localparam int TBL_DEPTH  = 2**DAC_ADDR_W;
   localparam logic [DAC_DATA_W-1:0] DAC_IDLE_CODE = 16'h8000;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_FIN} state_t;
endpackage

// File: rtl/dac_sample_table.sv
// Sample table: register array with one synchronous write port and two asynchronous read ports.
module dac_sample_table #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1
);
   // Contents are deliberately not reset so a table survives rst_n.
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];
endmodule

// File: rtl/dac_burst_sequencer.sv
// Plays the sample table as a two-channel burst with per-channel slot offsets and frame repeats.
module dac_burst_sequencer
   import dac_pkg::*;
#(
   parameter int DATA_W = DAC_DATA_W,
   parameter int ADDR_W = DAC_ADDR_W,
   parameter int DLY_W  = 8,
   parameter int REP_W  = 8,
   parameter logic [DATA_W-1:0] IDLE_CODE = DAC_IDLE_CODE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic [DLY_W-1:0]  cfg_dly0,
   input  logic [DLY_W-1:0]  cfg_dly1,
   input  logic [REP_W-1:0]  cfg_rep,
   input  logic              tbl_we,
   input  logic [ADDR_W-1:0] tbl_addr,
   input  logic [DATA_W-1:0] tbl_wdata,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [DATA_W-1:0] word_data0,
   output logic [DATA_W-1:0] word_data1,
   output logic              busy,
   output logic              done
);
   localparam int FW = DLY_W + ADDR_W + 1;

   state_t            state;
   logic [ADDR_W:0]   len_r;
   logic [DLY_W-1:0]  dly0_r, dly1_r, max_dly;
   logic [REP_W-1:0]  rep_r, frame;
   logic [FW-1:0]     f_r, f_next, k, next_k, slot, lo0, lo1, hi0, hi1;
   logic [ADDR_W-1:0] ra0, ra1;
   logic [DATA_W-1:0] rd0, rd1;
   logic              act0, act1, xfer, last_slot;

   dac_sample_table #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_tbl (
      .clk(clk), .we(tbl_we), .waddr(tbl_addr), .wdata(tbl_wdata),
      .raddr0(ra0), .raddr1(ra1), .rdata0(rd0), .rdata1(rd1)
   );

   assign xfer      = word_valid & word_ready;
   assign max_dly   = (dly0_r > dly1_r) ? dly0_r : dly1_r;
   assign f_next    = FW'(len_r) + FW'(max_dly);
   assign last_slot = (k == f_r - FW'(1));
   assign next_k    = last_slot ? '0 : k + FW'(1);
   // LOAD pre-registers slot 0; in RUN the lookup always targets the slot after the current one.
   assign slot      = (state == ST_LOAD) ? '0 : next_k;

   assign lo0  = FW'(dly0_r);
   assign lo1  = FW'(dly1_r);
   assign hi0  = lo0 + FW'(len_r);
   assign hi1  = lo1 + FW'(len_r);
   assign act0 = (slot >= lo0) && (slot < hi0);
   assign act1 = (slot >= lo1) && (slot < hi1);
   assign ra0  = ADDR_W'(slot - lo0);
   assign ra1  = ADDR_W'(slot - lo1);

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         word_valid <= 1'b0;
         word_data0 <= IDLE_CODE;
         word_data1 <= IDLE_CODE;
         done       <= 1'b0;
         len_r      <= '0;
         dly0_r     <= '0;
         dly1_r     <= '0;
         rep_r      <= '0;
         frame      <= '0;
         f_r        <= '0;
         k          <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  len_r  <= cfg_len;
                  dly0_r <= cfg_dly0;
                  dly1_r <= cfg_dly1;
                  rep_r  <= cfg_rep;
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else begin
                  f_r   <= f_next;
                  k     <= '0;
                  frame <= '0;
                  if (len_r == '0) begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                  end else begin
                     state      <= ST_RUN;
                     word_valid <= 1'b1;
                     word_data0 <= act0 ? rd0 : IDLE_CODE;
                     word_data1 <= act1 ? rd1 : IDLE_CODE;
                  end
               end
            end
            ST_RUN: begin
               // Abort wins over a simultaneous transfer; that pair is not replayed.
               if (abort) begin
                  state      <= ST_IDLE;
                  word_valid <= 1'b0;
               end else if (xfer) begin
                  if (last_slot && frame == rep_r) begin
                     state      <= ST_FIN;
                     word_valid <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     k          <= next_k;
                     if (last_slot) frame <= frame + REP_W'(1);
                     word_data0 <= act0 ? rd0 : IDLE_CODE;
                     word_data1 <= act1 ? rd1 : IDLE_CODE;
                  end
               end
            end
            ST_FIN: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
